// File: rtl/bi_shift_ctrl_if.sv
// Request/acknowledge bundle between the button/debounce logic (master)
// and the bi_shift_ctrl sequencer (slave).
interface bi_shift_ctrl_if;
    logic push_req;
    logic pop_req;
    logic push_bit;
    logic ready;
    logic ack;

    modport master (
        output push_req,
        output pop_req,
        output push_bit,
        input  ready,
        input  ack
    );

    modport slave (
        input  push_req,
        input  pop_req,
        input  push_bit,
        output ready,
        output ack
    );
endinterface

// File: rtl/bi_shift_ctrl.sv
// Push/pop sequencer for a DEPTH-stage bidirectional shift register.
// Optional feature: define BI_SHIFT_CTRL_OVF_DROP_EN to let a push while full shift out the oldest bit.
module bi_shift_ctrl #(
    parameter int DEPTH    = 4,
    parameter int CW       = 3,
    parameter int HOLD_CYC = 0,
    parameter int HW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    bi_shift_ctrl_if.slave req_if,
    output logic          sr_in,
    output logic          sr_enb,
    output logic          sr_dir,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          err_ovf,
    output logic          err_unf
);

`ifdef BI_SHIFT_CTRL_OVF_DROP_EN
    localparam bit OVF_DROP = 1'b1;
`else
    localparam bit OVF_DROP = 1'b0;
`endif

    localparam bit            HAS_HOLD  = (HOLD_CYC > 0);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          op_push_q, op_push_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_unf_q, err_unf_d;
    logic          ack_q, ack_d;
    logic          sr_enb_q, sr_enb_d;
    logic          sr_dir_q, sr_dir_d;
    logic          sr_in_q, sr_in_d;

    logic full_w;
    logic empty_w;
    logic any_req;

    assign full_w  = (count_q == COUNT_MAX);
    assign empty_w = (count_q == '0);
    assign any_req = req_if.push_req | req_if.pop_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                hold_cnt_d = '0;
                state_d    = HAS_HOLD ? HOLD : IDLE;
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                hold_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // Strobes are decided at acceptance so they appear, registered, during EXEC;
    // occupancy and sticky errors commit on the edge that ends EXEC.
    always_comb begin
        op_push_d = op_push_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        ack_d     = 1'b0;
        sr_enb_d  = 1'b0;
        sr_dir_d  = sr_dir_q;
        sr_in_d   = sr_in_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    op_push_d = req_if.push_req;
                    ack_d     = 1'b1;
                    sr_dir_d  = req_if.push_req;
                    sr_in_d   = req_if.push_req & req_if.push_bit;
                    sr_enb_d  = req_if.push_req ? (~full_w | OVF_DROP) : ~empty_w;
                end
            end
            EXEC: begin
                if (op_push_q) begin
                    if (full_w) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else begin
                    if (empty_w) begin
                        err_unf_d = 1'b1;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            default: begin
                op_push_d = op_push_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_push_q <= 1'b0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            ack_q     <= 1'b0;
            sr_enb_q  <= 1'b0;
            sr_dir_q  <= 1'b0;
            sr_in_q   <= 1'b0;
        end else begin
            op_push_q <= op_push_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            ack_q     <= ack_d;
            sr_enb_q  <= sr_enb_d;
            sr_dir_q  <= sr_dir_d;
            sr_in_q   <= sr_in_d;
        end
    end

    assign req_if.ready = (state_q == IDLE);
    assign req_if.ack   = ack_q;
    assign sr_in        = sr_in_q;
    assign sr_enb       = sr_enb_q;
    assign sr_dir       = sr_dir_q;
    assign count        = count_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign err_ovf      = err_ovf_q;
    assign err_unf      = err_unf_q;

endmodule
